spi_slave_param: RTL and testbench

Parametrised SPI slave front-end that deserialises MOSI frames into command-plus-payload words for the memory/register back-end and serialises read data back on MISO. Generalises the 8-bit-payload slave to any payload width. Adds:
- single-cycle `rx_valid` pulses
- mid-frame abort detection
- a read-data wait timeout
- an optional frame parity check

Sits between the SPI pins (system-clock-sampled, no separate SCK domain) and the RAM wrapper.

---
 rtl/spi_slave_param_if.sv | 25 ++
 rtl/spi_slave_param.sv | 195 +++++++++++++++++++
 tb/tb_spi_slave_param.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_param_if.sv
// SPI pin and back-end handshake bundle for spi_slave_param.
// slave modport is used by the SPI slave, master modport by whatever drives the pins and back-end.
interface spi_slave_param_if #(
  parameter int DATA_W = 8
);
  logic                SS_n;
  logic                MOSI;
  logic                MISO;
  logic [DATA_W+1:0]   rx_data;
  logic                rx_valid;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_valid;
  logic                frame_err;
  logic                rd_pending;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err, rd_pending
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err, rd_pending
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end, sampled on the system clock.
// Deserialises 2-bit command + DATA_W payload frames, returns DATA_W read data on MISO,
// flags aborted frames and read-data wait timeouts on frame_err.
// Optional feature macro: SPI_SLAVE_PARITY_EN adds a trailing even-parity bit to each receive frame.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_param_if.slave bus
);

  localparam int N = DATA_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int RX_BITS = N + 1;
`else
  localparam int RX_BITS = N;
`endif
  localparam int CNT_W = $clog2(RX_BITS + 1);
  localparam int TW    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TX_TIMEOUT > 0) ? TW'(TX_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_TX, DONE
  } state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [N-1:0]       r_rx_shift, w_rx_shift_next;
  logic [N-1:0]       r_rx_data, w_rx_data_next;
  logic               r_rx_valid, w_rx_valid_next;
  logic               r_frame_err, w_frame_err_next;
  logic               r_rd_pending, w_rd_pending_next;
  logic [DATA_W-1:0]  r_tx_shift, w_tx_shift_next;
  logic               r_miso, w_miso_next;
  logic [TW-1:0]      r_wait, w_wait_next;
  logic [N-1:0]       w_rx_word;
  logic               w_par_ok;
  logic               w_last;
`ifdef SPI_SLAVE_PARITY_EN
  logic               r_par, w_par_next;
`endif

  assign bus.MISO       = r_miso;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.rd_pending = r_rd_pending;

  // Completed-word view: with parity the last sampled bit is the parity bit, otherwise it is the payload LSB.
`ifdef SPI_SLAVE_PARITY_EN
  assign w_rx_word = r_rx_shift;
  assign w_par_ok  = (r_par == bus.MOSI);
`else
  assign w_rx_word = {r_rx_shift[N-2:0], bus.MOSI};
  assign w_par_ok  = 1'b1;
`endif
  assign w_last = (r_cnt == CNT_W'(1));

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rd_pending <= 1'b0;
      r_tx_shift   <= '0;
      r_miso       <= 1'b0;
      r_wait       <= '0;
`ifdef SPI_SLAVE_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_rx_shift   <= w_rx_shift_next;
      r_rx_data    <= w_rx_data_next;
      r_rx_valid   <= w_rx_valid_next;
      r_frame_err  <= w_frame_err_next;
      r_rd_pending <= w_rd_pending_next;
      r_tx_shift   <= w_tx_shift_next;
      r_miso       <= w_miso_next;
      r_wait       <= w_wait_next;
`ifdef SPI_SLAVE_PARITY_EN
      r_par        <= w_par_next;
`endif
    end
  end

  // Next-state and next-value logic; pulses default low, everything else holds.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_rx_shift_next   = r_rx_shift;
    w_rx_data_next    = r_rx_data;
    w_rx_valid_next   = 1'b0;
    w_frame_err_next  = 1'b0;
    w_rd_pending_next = r_rd_pending;
    w_tx_shift_next   = r_tx_shift;
    w_miso_next       = r_miso;
    w_wait_next       = r_wait;
`ifdef SPI_SLAVE_PARITY_EN
    w_par_next        = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_miso_next = 1'b0;
        if (!bus.SS_n) w_state_next = CHK_CMD;
      end
      CHK_CMD: begin
        // Read/write bit is consumed here and never stored.
        w_cnt_next = CNT_W'(RX_BITS);
`ifdef SPI_SLAVE_PARITY_EN
        w_par_next = 1'b0;
`endif
        if (bus.SS_n)             w_state_next = IDLE;
        else if (!bus.MOSI)       w_state_next = WRITE;
        else if (r_rd_pending)    w_state_next = READ_DATA;
        else                      w_state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (w_last) begin
          // Last bit counts even if SS_n rises on this very edge.
          if (w_par_ok) begin
            w_rx_data_next  = w_rx_word;
            w_rx_valid_next = 1'b1;
            if (r_state == READ_ADD) w_rd_pending_next = 1'b1;
            w_state_next = (r_state == READ_DATA) ? WAIT_TX : DONE;
            w_wait_next  = '0;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = DONE;
          end
          if (bus.SS_n) w_state_next = IDLE;
        end else if (bus.SS_n) begin
          w_frame_err_next = 1'b1;
          w_state_next     = IDLE;
        end else begin
          w_cnt_next      = r_cnt - CNT_W'(1);
          w_rx_shift_next = {r_rx_shift[N-2:0], bus.MOSI};
`ifdef SPI_SLAVE_PARITY_EN
          w_par_next      = r_par ^ bus.MOSI;
`endif
        end
      end
      WAIT_TX: begin
        if (bus.SS_n) begin
          w_frame_err_next = 1'b1;
          w_state_next     = IDLE;
        end else if (bus.tx_valid) begin
          // MSB goes straight onto MISO; the shifter holds the remaining bits.
          w_miso_next     = bus.tx_data[DATA_W-1];
          w_tx_shift_next = {bus.tx_data[DATA_W-2:0], 1'b0};
          w_cnt_next      = CNT_W'(DATA_W - 1);
          w_state_next    = SHIFT_TX;
        end else if (TX_TIMEOUT != 0) begin
          if (r_wait == TO_LAST) begin
            w_frame_err_next = 1'b1;
            w_state_next     = DONE;
          end else begin
            w_wait_next = r_wait + TW'(1);
          end
        end
      end
      SHIFT_TX: begin
        if (bus.SS_n) begin
          w_frame_err_next = 1'b1;
          w_miso_next      = 1'b0;
          w_state_next     = IDLE;
        end else if (r_cnt == '0) begin
          w_rd_pending_next = 1'b0;
          w_miso_next       = 1'b0;
          w_state_next      = DONE;
        end else begin
          w_miso_next     = r_tx_shift[DATA_W-1];
          w_tx_shift_next = {r_tx_shift[DATA_W-2:0], 1'b0};
          w_cnt_next      = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        w_miso_next = 1'b0;
        if (bus.SS_n) w_state_next = IDLE;
      end
      default: begin
        w_miso_next  = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed self-checking bench for spi_slave_param (DATA_W=8, TX_TIMEOUT=4).
// Builds with or without SPI_SLAVE_PARITY_EN; the stimulus appends the parity bit when it is defined.
module tb_spi_slave_param;

`ifdef SPI_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk;
  logic rst;

  spi_slave_param_if #(.DATA_W(8)) bus_if ();

  spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int edge_no, rxv_cnt, ferr_cnt, miso_hi, both_cnt, rxv_cycle;
  logic [7:0] miso_seq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then observe outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    if (bus_if.rx_valid) begin
      rxv_cnt++;
      rxv_cycle = edge_no + 1;
    end
    if (bus_if.frame_err) ferr_cnt++;
    if (bus_if.MISO) miso_hi++;
    if (bus_if.rx_valid && bus_if.frame_err) both_cnt++;
  endtask

  task automatic clear_mon();
    edge_no = -1; rxv_cnt = 0; ferr_cnt = 0; miso_hi = 0; both_cnt = 0; rxv_cycle = -1;
  endtask

  // Drive SS_n low, rw bit, then nbits of the 10-bit word MSB first (plus parity if enabled and complete).
  task automatic send_frame(input logic rw, input logic [9:0] w, input int nbits, input logic bad_par);
    clear_mon();
    bus_if.SS_n = 1'b0;
    bus_if.MOSI = 1'b0;
    tick();
    bus_if.MOSI = rw;
    tick();
    for (int i = 0; i < nbits; i++) begin
      bus_if.MOSI = w[9-i];
      tick();
    end
    if (PAR == 1 && nbits == 10) begin
      bus_if.MOSI = (^w) ^ bad_par;
      tick();
    end
    bus_if.MOSI = 1'b0;
  endtask

  task automatic end_frame(input string name);
    bus_if.SS_n = 1'b1;
    tick();
    tick();
    $display("frame %s: rx_data=%03h rx_valid_pulses=%0d frame_err_pulses=%0d rd_pending=%0b",
             name, bus_if.rx_data, rxv_cnt, ferr_cnt, bus_if.rd_pending);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.SS_n = 1'b1;
    bus_if.MOSI = 1'b0;
    bus_if.tx_data = 8'h00;
    bus_if.tx_valid = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("reset_miso", bus_if.MISO, 0);
    check("reset_rx_data", bus_if.rx_data, 0);
    check("reset_rx_valid", bus_if.rx_valid, 0);
    check("reset_frame_err", bus_if.frame_err, 0);
    check("reset_rd_pending", bus_if.rd_pending, 0);
    rst = 1'b0;
    tick();

    // Write frame 00 / 0xA5.
    send_frame(1'b0, 10'h0A5, 10, 1'b0);
    check("wr_rx_valid_cycle", rxv_cycle, 12 + PAR);
    end_frame("write_a5");
    check("wr_rx_data", bus_if.rx_data, 10'h0A5);
    check("wr_rx_valid_pulses", rxv_cnt, 1);
    check("wr_frame_err", ferr_cnt, 0);
    check("wr_miso_quiet", miso_hi, 0);

`ifdef SPI_SLAVE_PARITY_EN
    // Bad parity: no update, frame_err instead of rx_valid.
    send_frame(1'b0, 10'h0F0, 10, 1'b1);
    end_frame("write_bad_parity");
    check("par_frame_err", ferr_cnt, 1);
    check("par_rx_valid", rxv_cnt, 0);
    check("par_rx_data_kept", bus_if.rx_data, 10'h0A5);
`endif

    // Read-address frame 10 / 0x3C.
    send_frame(1'b1, 10'h23C, 10, 1'b0);
    check("ra_rd_pending", bus_if.rd_pending, 1);
    end_frame("read_addr_3c");
    check("ra_rx_data", bus_if.rx_data, 10'h23C);
    check("ra_rx_valid_pulses", rxv_cnt, 1);
    check("ra_rd_pending_held", bus_if.rd_pending, 1);

    // Read-data frame 11 / 0x00, tx_valid two cycles after rx_valid, data 0xC3.
    bus_if.tx_data = 8'hC3;
    send_frame(1'b1, 10'h300, 10, 1'b0);
    check("rd_rx_valid_now", bus_if.rx_valid, 1);
    tick();
    tick();
    bus_if.tx_valid = 1'b1;
    tick();
    bus_if.tx_valid = 1'b0;
    miso_seq = {7'd0, bus_if.MISO};
    for (int i = 0; i < 7; i++) begin
      tick();
      miso_seq = {miso_seq[6:0], bus_if.MISO};
    end
    check("rd_miso_bits", miso_seq, 8'hC3);
    check("rd_pending_before_end", bus_if.rd_pending, 1);
    tick();
    check("rd_pending_cleared", bus_if.rd_pending, 0);
    check("rd_miso_after", bus_if.MISO, 0);
    end_frame("read_data_c3");
    check("rd_rx_data", bus_if.rx_data, 10'h300);
    check("rd_frame_err", ferr_cnt, 0);
    check("rd_no_collision", both_cnt, 0);

    // Abort a write after 5 payload bits.
    send_frame(1'b0, 10'h155, 5, 1'b0);
    end_frame("write_aborted");
    check("ab_frame_err", ferr_cnt, 1);
    check("ab_rx_valid", rxv_cnt, 0);
    check("ab_rx_data_kept", bus_if.rx_data, 10'h300);
    send_frame(1'b0, 10'h15A, 10, 1'b0);
    end_frame("write_after_abort");
    check("ab_next_rx_data", bus_if.rx_data, 10'h15A);
    check("ab_next_frame_err", ferr_cnt, 0);

    // Timeout: address frame then a read-data frame with tx_valid low.
    send_frame(1'b1, 10'h211, 10, 1'b0);
    end_frame("read_addr_11");
    check("to_rd_pending_set", bus_if.rd_pending, 1);
    send_frame(1'b1, 10'h3FF, 10, 1'b0);
    tick();
    tick();
    tick();
    check("to_no_err_yet", ferr_cnt, 0);
    tick();
    check("to_frame_err_pulse", bus_if.frame_err, 1);
    check("to_rd_pending_kept", bus_if.rd_pending, 1);
    end_frame("read_data_timeout");
    check("to_frame_err_count", ferr_cnt, 1);
    check("to_miso_quiet", miso_hi, 0);

    // Reset in the middle of SHIFT_TX, tx_valid already high on entry to WAIT_TX.
    bus_if.tx_data = 8'hFF;
    bus_if.tx_valid = 1'b1;
    send_frame(1'b1, 10'h300, 10, 1'b0);
    tick();
    tick();
    tick();
    check("rst_pre_miso", bus_if.MISO, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_miso", bus_if.MISO, 0);
    check("rst_async_rx_data", bus_if.rx_data, 0);
    check("rst_async_frame_err", bus_if.frame_err, 0);
    check("rst_async_rd_pending", bus_if.rd_pending, 0);
    bus_if.tx_valid = 1'b0;
    bus_if.SS_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    // After reset the FSM is idle with no pending read, so a read frame is an address frame.
    send_frame(1'b1, 10'h2AB, 10, 1'b0);
    end_frame("read_addr_after_reset");
    check("post_rst_rx_data", bus_if.rx_data, 10'h2AB);
    check("post_rst_rd_pending", bus_if.rd_pending, 1);
    check("post_rst_rx_valid", rxv_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
